// File: rtl/dp_ram_ind_rw.sv
// rtl/dp_ram_ind_rw.sv - simple dual-port RAM, one write port and one independent read port
// SYNC_READ selects combinational (LUT-RAM) or registered read-first (block-RAM) read data.
module dp_ram_ind_rw #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_DEPTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          SYNC_READ  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  if (DATA_DEPTH == 0) begin : g_err_depth_zero
    $error("dp_ram_ind_rw: DATA_DEPTH must be at least 1");
  end
  if (DATA_DEPTH > (2 ** ADDR_WIDTH)) begin : g_err_depth_large
    $error("dp_ram_ind_rw: DATA_DEPTH exceeds 2**ADDR_WIDTH");
  end

  // No reset on the array so synthesis can still map it onto RAM primitives.
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic                  waddr_ok;
  logic                  raddr_ok;
  logic [DATA_WIDTH-1:0] mem_rd;

  assign waddr_ok = 32'(waddr_i) < DATA_DEPTH;
  assign raddr_ok = 32'(raddr_i) < DATA_DEPTH;

  always_ff @(posedge clk_i) begin
    if (we_i && waddr_ok) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign mem_rd = raddr_ok ? mem[raddr_i] : '0;

  if (SYNC_READ) begin : g_sync_read
    logic [DATA_WIDTH-1:0] rdata_q;

    // Sampling the array before the same-edge write lands gives read-first ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= mem_rd;
      end
    end

    assign rdata_o = rdata_q;
  end else begin : g_async_read
    assign rdata_o = mem_rd;
  end

endmodule

// File: tb/tb_dp_ram_ind_rw.sv
// tb/tb_dp_ram_ind_rw.sv - directed self-checking bench for dp_ram_ind_rw
// Four instances share the stimulus: async/sync read at depth 8 and at depth 6.
module tb_dp_ram_ind_rw;

  logic        clk_i;
  logic        rst_ni;
  logic        we_i;
  logic [2:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [2:0]  raddr_i;
  logic [31:0] rdata_a8;
  logic [31:0] rdata_s8;
  logic [31:0] rdata_a6;
  logic [31:0] rdata_s6;

  int n_tests;
  int n_fail;

  dp_ram_ind_rw #(.ADDR_WIDTH(3), .DATA_DEPTH(8), .DATA_WIDTH(32), .SYNC_READ(1'b0)) u_a8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_a8)
  );
  dp_ram_ind_rw #(.ADDR_WIDTH(3), .DATA_DEPTH(8), .DATA_WIDTH(32), .SYNC_READ(1'b1)) u_s8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_s8)
  );
  dp_ram_ind_rw #(.ADDR_WIDTH(3), .DATA_DEPTH(6), .DATA_WIDTH(32), .SYNC_READ(1'b0)) u_a6 (
    .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_a6)
  );
  dp_ram_ind_rw #(.ADDR_WIDTH(3), .DATA_DEPTH(6), .DATA_WIDTH(32), .SYNC_READ(1'b1)) u_s6 (
    .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_s6)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we_i    = 1'b1;
    waddr_i = a;
    wdata_i = d;
    step();
    we_i    = 1'b0;
  endtask

  initial begin
    logic [31:0] exp8;
    logic [31:0] exp6;
    n_tests = 0;
    n_fail  = 0;
    rst_ni  = 1'b0;
    we_i    = 1'b0;
    waddr_i = '0;
    wdata_i = '0;
    raddr_i = '0;

    #1;
    check("reset_s8", rdata_s8, 32'h0);
    check("reset_s6", rdata_s6, 32'h0);
    step();
    check("reset_hold_s8", rdata_s8, 32'h0);
    rst_ni = 1'b1;
    step();

    // Async write then read
    wr(3'd3, 32'hDEAD_BEEF);
    raddr_i = 3'd3;
    #1;
    check("async_wr_rd_a8", rdata_a8, 32'hDEAD_BEEF);
    check("async_wr_rd_a6", rdata_a6, 32'hDEAD_BEEF);

    // Async same-cycle write/read: old word before the edge, new word after
    wr(3'd5, 32'h11);
    raddr_i = 3'd5;
    we_i    = 1'b1;
    waddr_i = 3'd5;
    wdata_i = 32'h22;
    #1;
    check("async_rdw_old", rdata_a8, 32'h11);
    step();
    we_i = 1'b0;
    check("async_rdw_new", rdata_a8, 32'h22);

    // Sync latency and read-first
    wr(3'd2, 32'hA5);
    raddr_i = 3'd2;
    we_i    = 1'b1;
    waddr_i = 3'd2;
    wdata_i = 32'h5A;
    step();
    we_i = 1'b0;
    check("sync_read_first", rdata_s8, 32'hA5);
    step();
    check("sync_new_word", rdata_s8, 32'h5A);

    // Sync reset mid-stream; a write issued while in reset must still land
    rst_ni = 1'b0;
    #1;
    check("sync_rst_immediate", rdata_s8, 32'h0);
    wr(3'd4, 32'h44);
    check("sync_rst_across_edge", rdata_s8, 32'h0);
    rst_ni = 1'b1;
    #1;
    check("sync_rst_released", rdata_s8, 32'h0);
    step();
    check("sync_after_rst", rdata_s8, 32'h5A);
    raddr_i = 3'd4;
    #1;
    check("write_during_rst", rdata_a8, 32'h44);

    // Full sweep; on depth 6 the writes to 6 and 7 are dropped
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 32'(i) * 32'h0101_0101);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 7; i >= 0; i--) begin
        exp8    = 32'(i) * 32'h0101_0101;
        exp6    = (i < 6) ? exp8 : 32'h0;
        raddr_i = 3'(i);
        we_i    = 1'b0;
        wdata_i = $urandom;
        waddr_i = 3'(i);
        #1;
        check($sformatf("sweep_a8_p%0d_%0d", pass, i), rdata_a8, exp8);
        check($sformatf("sweep_a6_p%0d_%0d", pass, i), rdata_a6, exp6);
        step();
        check($sformatf("sweep_s8_p%0d_%0d", pass, i), rdata_s8, exp8);
        check($sformatf("sweep_s6_p%0d_%0d", pass, i), rdata_s6, exp6);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
